// File: rtl/bluetooth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bluetooth_pkg
//  Description : Shared UART timing default, TX FSM state type and the
//                clock-symbol to ASCII encoder used by TX and RX.
//  Revision    : 1.0 - initial release
// ============================================================================
package bluetooth_pkg;

  localparam int BPS = 10417;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // 0..9 -> '0'..'9', 10..23 -> 'A'..'N', anything else -> '?'
  function automatic logic [7:0] sym_to_ascii(input logic [4:0] sym);
    logic [7:0] r;
    if (sym <= 5'd9) begin
      r = 8'd48 + {3'b000, sym};
    end else if (sym <= 5'd23) begin
      r = 8'd55 + {3'b000, sym};
    end else begin
      r = 8'd63;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bluetooth_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bluetooth_tx_fifo
//  Description : Synchronous FIFO with a show-ahead head and occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module bluetooth_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [c_PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_PW:0]    count_q, count_d;
  logic             w_do_push, w_do_pop;

  assign full      = (count_q == (c_PW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + c_PW'(1);
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + c_PW'(1);
    end
    // Simultaneous push and pop leaves occupancy unchanged
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + (c_PW+1)'(1);
      2'b01:   count_d = count_q - (c_PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/bluetooth_tx.sv
`default_nettype none
// ============================================================================
//  Module      : bluetooth_tx
//  Description : Buffers clock symbols, encodes them to ASCII and sends them
//                as 8N1 UART frames to a Bluetooth module.
//  Revision    : 1.0 - initial release
// ============================================================================
module bluetooth_tx #(
  parameter int BPS        = bluetooth_pkg::BPS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [4:0] in_data,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  import bluetooth_pkg::*;

  localparam int c_CNT_W = (BPS > 1) ? $clog2(BPS) : 1;
  localparam int c_OCC_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_e            state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           shreg_q, shreg_d;
  logic                 tx_q, tx_d;

  logic                 w_push, w_pop, w_full, w_empty, w_bit_end;
  logic [7:0]           w_head;
  logic [c_OCC_W-1:0]   w_count;

  assign in_ready  = !w_full && !rst;
  assign w_push    = in_valid && in_ready;
  assign w_bit_end = (cnt_q == c_CNT_W'(BPS - 1));
  assign tx        = tx_q;
  assign busy      = !rst && ((state_q != IDLE) || (w_count != '0));

  bluetooth_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (sym_to_ascii(in_data)),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    w_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          shreg_d = w_head;
          tx_d    = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shreg_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // Next bit is shreg[1]; shifting keeps the LSB as the live bit
            idx_d   = idx_q + 3'd1;
            tx_d    = shreg_q[1];
            shreg_d = shreg_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end
      STOP: begin
        if (w_bit_end) begin
          cnt_d = '0;
          if (!w_empty) begin
            w_pop   = 1'b1;
            shreg_d = w_head;
            tx_d    = 1'b0;
            idx_d   = '0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bluetooth_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bluetooth_tx
//  Description : Directed self-checking bench for bluetooth_tx (BPS=16, depth 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bluetooth_tx;

  localparam int BPS    = 16;
  localparam int DEPTH  = 4;
  localparam int c_WAIT = 400;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_ready;
  logic       tx;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  logic [4:0] stim  [32];
  logic [7:0] exp_b [32];

  bluetooth_tx #(
    .BPS        (BPS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Receiver-side decode of the ASCII byte back to a clock symbol
  function automatic int ascii_to_sym(input logic [7:0] b);
    if (b >= 8'd48 && b <= 8'd57) return int'(b) - 48;
    if (b >= 8'd65 && b <= 8'd78) return int'(b) - 55;
    return 31;
  endfunction

  task automatic push_one(input logic [4:0] s);
    int w;
    w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = s;
    while (!in_ready && w < c_WAIT) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Waits for a start bit, then samples every bit at its middle
  task automatic recv_frame(output logic [7:0] b, output int gap);
    int w;
    b = '0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx !== 1'b0 && w < c_WAIT);
    gap = w;
    if (tx !== 1'b0) begin
      check("rx_start_timeout", {31'd0, tx}, 32'd0);
      return;
    end
    repeat (BPS/2) @(negedge clk);
    check("start_bit", {31'd0, tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (BPS) @(negedge clk);
      b[i] = tx;
    end
    repeat (BPS) @(negedge clk);
    check("stop_bit", {31'd0, tx}, 32'd1);
  endtask

  task automatic push_stream(input int n, input bit chk_drop);
    int  k, cyc;
    bit  acc, blocked;
    k = 0; cyc = 0; blocked = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = stim[0];
    while (k < n && cyc < 6000) begin
      acc = in_ready;
      if (!acc && chk_drop && !blocked) begin
        blocked = 1'b1;
        check("accepts_before_full", k, 5);
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        k++;
        if (k < n) in_data = stim[k];
        else       in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("push_count", k, n);
  endtask

  task automatic recv_stream(input int n, input bit decode);
    logic [7:0] b;
    int         gap;
    for (int i = 0; i < n; i++) begin
      recv_frame(b, gap);
      if (i > 0) check("gap", gap, BPS/2);
      if (decode) check("rx_sym", ascii_to_sym(b), i);
      else        check("rx_byte", {24'd0, b}, {24'd0, exp_b[i]});
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int         gap, lows;

    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_tx", {31'd0, tx}, 32'd1);

    // Single symbol 5 -> '5' = 8'h35, exact latency and frame length
    push_one(5'd5);
    recv_frame(b, gap);
    check("latency_gap", gap, 2);
    check("byte_5", {24'd0, b}, 32'h35);
    repeat (BPS/2 - 1) @(negedge clk);
    check("busy_end_frame", {31'd0, busy}, 32'd1);
    check("tx_end_frame", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("busy_after_160", {31'd0, busy}, 32'd0);

    // Back-to-back 23, 10 -> 'N', 'A' with no idle gap
    push_one(5'd23);
    push_one(5'd10);
    recv_frame(b, gap);
    check("byte_23", {24'd0, b}, 32'h4E);
    recv_frame(b, gap);
    check("b2b_gap", gap, BPS/2);
    check("byte_10", {24'd0, b}, 32'h41);
    wait_idle();

    // Six symbols streamed; FIFO fills after 5 accepts, order kept
    stim[0] = 5'd0;  exp_b[0] = 8'h30;
    stim[1] = 5'd9;  exp_b[1] = 8'h39;
    stim[2] = 5'd12; exp_b[2] = 8'h43;
    stim[3] = 5'd17; exp_b[3] = 8'h48;
    stim[4] = 5'd22; exp_b[4] = 8'h4D;
    stim[5] = 5'd3;  exp_b[5] = 8'h33;
    fork
      push_stream(6, 1'b1);
      recv_stream(6, 1'b0);
    join
    wait_idle();

    // Out-of-range symbols encode to '?'
    push_one(5'd30);
    recv_frame(b, gap);
    check("byte_30", {24'd0, b}, 32'h3F);
    wait_idle();

    // Reset mid-frame with two symbols queued
    push_one(5'd1);
    push_one(5'd2);
    push_one(5'd3);
    repeat (38) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_release_ready", {31'd0, in_ready}, 32'd1);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("no_frame_after_rst", lows, 0);

    // Loop-back decode of every symbol 0..23
    for (int i = 0; i < 24; i++) stim[i] = 5'(i);
    fork
      push_stream(24, 1'b0);
      recv_stream(24, 1'b1);
    join
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
